uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver. It is the receive-side counterpart of the team's UART transmitter and accepts the same frame format: start bit, Data_WD data bits LSB-first, optional parity bit, and one stop bit.
- The serial line is oversampled by a runtime prescale. Each bit is decided by a 3-sample majority vote around mid-bit.
- Completed frames are presented as a parallel word with a one-cycle valid strobe. Parity and stop errors are flagged separately.
- It sits between the RX pad and the host-side register/FIFO logic.

Parameters:
- Data_WD, 8, number of data bits per frame.

Ports:
- CLK  input  1  oversampling clock.
- RST  input  1  synchronous reset, active-high.
- RX_IN  input  1  serial line; idle high; asynchronous to CLK.
- Prescale  input  6  oversampling factor; legal values are 8, 16 and 32.
- PAR_EN  input  1  1 = a parity bit is present in the frame.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  Data_WD  last received data word.
- data_valid  output  1  one-cycle strobe when a frame completes with no error.
- par_err  output  1  one-cycle strobe when the parity check fails.
- stp_err  output  1  one-cycle strobe when the stop bit is sampled 0.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-high, on CLK/RST. Under RST=1 at a CLK edge:
  - FSM goes to IDLE; all counters clear.
  - Synchronizer flops are set to 1.
  - P_DATA=0, data_valid=0, par_err=0, stp_err=0.
- Reset mid-frame aborts the frame with no strobe.
- Input sync: RX_IN passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- Prescale, PAR_EN and PAR_TYP are latched on leaving IDLE. Changes mid-frame have no effect on the frame in progress. An illegal Prescale value is treated as 8.
- Counters:
  - edge_cnt runs 0..P-1 and wraps.
  - bit_cnt counts frame bits.
  - F = 2 + Data_WD + PAR_EN.
- Sampling: rx_s is captured at edge_cnt = P/2-1, P/2 and P/2+1. The bit value is the majority of the three samples, resolved at edge_cnt = P/2+1.
- FSM states:
  - IDLE: on rx_s=0, go to START with edge_cnt=0.
  - START: at resolve, if the voted bit is 1 (glitch), go to IDLE immediately with no strobe. Otherwise, at edge_cnt=P-1, go to DATA.
  - DATA: shift the voted bit into the MSB of the shift register (so the LSB arrives first). After Data_WD bits, go to PARITY if PAR_EN=1, else go to STOP.
  - PARITY: expected bit = ^data XOR PAR_TYP. A mismatch is recorded at resolve.
  - STOP: a voted 0 is a stop error.
  - At edge_cnt=P-1 of the stop bit, go to IDLE (stop bit = 1) or WAIT_HI (stop bit = 0).
  - WAIT_HI: stay until rx_s=1, then go to IDLE. A held-low break therefore yields exactly one stp_err.
- Strobes are registered. Let edge 0 be the first CLK edge at which RX_IN is sampled 0. The strobes are high for exactly the cycle following edge 2+F*P:
  - No errors: data_valid=1 and P_DATA is updated in the same cycle. P_DATA holds until the next valid frame.
  - Any error: data_valid=0 and P_DATA is unchanged. par_err and stp_err assert independently; both may be 1 together.
- Back-to-back frames: a start bit detected in the IDLE cycle immediately after the stop bit must be accepted. There is zero idle gap requirement.
- No flow control: the consumer must take P_DATA on data_valid.

Decomposition:
- Package uart_pkg holds:
  - rx_state_e enum: IDLE, START, DATA, PARITY, STOP, WAIT_HI.
  - Legal-prescale constants: PRESC_8, PRESC_16, PRESC_32.
  - A parity function shared with the transmitter's parity calculation.
- One sub-module, uart_rx_sampler. It contains the synchronizer, edge_cnt, and the 3-sample majority. It outputs sampled_bit and a resolve strobe, plus a bit_end strobe at edge_cnt=P-1.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 -> data_valid pulses once, 2+10*8 cycles after the start edge; P_DATA=0xA5; par_err=0; stp_err=0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x37 with parity bit 1 -> P_DATA=0x37, no errors. Same frame sent with parity bit 0 -> par_err=1, data_valid=0, P_DATA unchanged.
- Prescale=32, PAR_EN=1, PAR_TYP=1, data 0xFF with stop bit 0 -> stp_err=1, data_valid=0. Line then held low 100 cycles -> no further strobes; line released -> next frame 0x12 received correctly.
- RX_IN low for 3 cycles at Prescale=16 (glitch) -> return to IDLE with no strobes. A following frame 0x5A -> P_DATA=0x5A.
- Two frames 0x01 then 0x80 back-to-back, Prescale=8, with single-cycle noise inverting the center sample of each bit -> majority vote gives two data_valid pulses, P_DATA=0x01 then 0x80.
- RST asserted for 1 cycle mid-DATA of frame 0xC3 -> all outputs 0 the next cycle, no strobe. A subsequent frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types, legal prescale constants and the parity
//                helper used by both the transmitter and the receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver frame-tracking states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        WAIT_HI = 3'd5
    } rx_state_e;

    // The only oversampling factors the receiver supports.
    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    // Widest data word the parity helper accepts; narrower words are
    // zero-extended, which does not change the XOR reduction.
    localparam int c_PAR_MAX_W = 32;

    // Expected parity bit: even parity when odd=0, odd parity when odd=1.
    function automatic logic calc_parity(input logic [c_PAR_MAX_W-1:0] data,
                                         input logic                   odd);
        return (^data) ^ odd;
    endfunction

    // Any prescale outside the supported set falls back to 8.
    function automatic logic [5:0] legal_prescale(input logic [5:0] presc);
        logic [5:0] w_sel;
        case (presc)
            PRESC_16: w_sel = PRESC_16;
            PRESC_32: w_sel = PRESC_32;
            default:  w_sel = PRESC_8;
        endcase
        return w_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : RX line synchronizer, per-bit oversampling counter and
//                3-sample majority vote around mid-bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    input  logic [5:0] i_presc,
    input  logic       i_run,
    output logic       o_rx_s,
    output logic       o_bit,
    output logic       o_resolve,
    output logic       o_bit_end
);

    logic [1:0] r_sync;
    logic [5:0] r_edge_cnt;
    logic       r_s0;
    logic       r_s1;
    logic [5:0] w_half;
    logic [5:0] w_half_m1;
    logic [5:0] w_half_p1;
    logic [5:0] w_last;

    assign w_half    = i_presc >> 1;
    assign w_half_m1 = w_half - 6'd1;
    assign w_half_p1 = w_half + 6'd1;
    assign w_last    = i_presc - 6'd1;

    assign o_rx_s = r_sync[1];

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    // Bit-period counter: held at 0 while no frame is active so a detected
    // start edge always begins counting from 0.
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_edge_cnt <= 6'd0;
        end else if (r_edge_cnt == w_last) begin
            r_edge_cnt <= 6'd0;
        end else begin
            r_edge_cnt <= r_edge_cnt + 6'd1;
        end
    end

    // Capture the first two of the three mid-bit samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
        end else if (i_run) begin
            if (r_edge_cnt == w_half_m1) begin
                r_s0 <= o_rx_s;
            end
            if (r_edge_cnt == w_half) begin
                r_s1 <= o_rx_s;
            end
        end
    end

    // Third sample is the live line value; the vote is valid at resolve.
    assign o_bit     = (r_s0 & r_s1) | (r_s0 & o_rx_s) | (r_s1 & o_rx_s);
    assign o_resolve = i_run && (r_edge_cnt == w_half_p1);
    assign o_bit_end = i_run && (r_edge_cnt == w_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : UART receiver. Start bit, Data_WD data bits LSB-first,
//                optional parity, one stop bit. Majority-voted sampling,
//                registered valid / parity-error / stop-error strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int Data_WD = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [5:0]         Prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    output logic [Data_WD-1:0] P_DATA,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err
);

    localparam int                 c_BIT_W    = $clog2(Data_WD + 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(Data_WD - 1);

    rx_state_e            r_state;
    logic [5:0]           r_presc;
    logic                 r_par_en;
    logic                 r_par_typ;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [Data_WD-1:0]   r_shift;
    logic                 r_par_bad;
    logic                 r_stp_bad;

    logic                 w_run;
    logic                 w_rx_s;
    logic                 w_bit;
    logic                 w_resolve;
    logic                 w_bit_end;

    // The bit-period counter only runs while a frame's bits are being timed.
    assign w_run = (r_state == START) || (r_state == DATA) ||
                   (r_state == PARITY) || (r_state == STOP);

    uart_rx_sampler u_sampler (
        .clk       (CLK),
        .rst       (RST),
        .i_rx      (RX_IN),
        .i_presc   (r_presc),
        .i_run     (w_run),
        .o_rx_s    (w_rx_s),
        .o_bit     (w_bit),
        .o_resolve (w_resolve),
        .o_bit_end (w_bit_end)
    );

    // Frame FSM with registered data word and one-cycle result strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= IDLE;
            r_presc    <= PRESC_8;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bad  <= 1'b0;
            r_stp_bad  <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            case (r_state)
                IDLE: begin
                    // Frame configuration is frozen for the whole frame here.
                    if (!w_rx_s) begin
                        r_state   <= START;
                        r_presc   <= legal_prescale(Prescale);
                        r_par_en  <= PAR_EN;
                        r_par_typ <= PAR_TYP;
                        r_bit_cnt <= '0;
                        r_par_bad <= 1'b0;
                        r_stp_bad <= 1'b0;
                    end
                end

                START: begin
                    // A start bit that votes high was line noise: drop it.
                    if (w_resolve && w_bit) begin
                        r_state <= IDLE;
                    end else if (w_bit_end) begin
                        r_state <= DATA;
                    end
                end

                DATA: begin
                    if (w_resolve) begin
                        r_shift <= {w_bit, r_shift[Data_WD-1:1]};
                    end
                    if (w_bit_end) begin
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                        end
                    end
                end

                PARITY: begin
                    if (w_resolve) begin
                        r_par_bad <= (w_bit != calc_parity(c_PAR_MAX_W'(r_shift), r_par_typ));
                    end
                    if (w_bit_end) begin
                        r_state <= STOP;
                    end
                end

                STOP: begin
                    if (w_resolve) begin
                        r_stp_bad <= ~w_bit;
                    end
                    if (w_bit_end) begin
                        par_err <= r_par_bad;
                        stp_err <= r_stp_bad;
                        if (!r_par_bad && !r_stp_bad) begin
                            data_valid <= 1'b1;
                            P_DATA     <= r_shift;
                        end
                        // A low stop bit may be a break: wait for the line to
                        // return high so the break reports only once.
                        r_state <= r_stp_bad ? WAIT_HI : IDLE;
                    end
                end

                WAIT_HI: begin
                    if (w_rx_s) begin
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx with a strobe
//                scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [5:0]    Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    uart_rx #(.Data_WD(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 CLK = ~CLK;

    // Posedge counter used to measure strobe latency.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] pdata;
        int         start;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_fail   = 0;
    logic [7:0] model_pdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every strobe cycle is matched against the oldest expected frame result.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST && (data_valid || par_err || stp_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {29'd0, data_valid, par_err, stp_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("data_valid", {31'd0, data_valid}, {31'd0, e.dv});
                chk("par_err",    {31'd0, par_err},    {31'd0, e.pe});
                chk("stp_err",    {31'd0, stp_err},    {31'd0, e.se});
                chk("P_DATA",     {24'd0, P_DATA},     {24'd0, e.pdata});
                if (e.lat >= 0) begin
                    chk("latency", cyc - e.start, e.lat);
                end
            end
        end
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk(tag, sb.size(), 32'd0);
    endtask

    // Drives one frame bit-by-bit (peff cycles per bit) and queues its result.
    task automatic send_frame(input logic [7:0] data, input logic [5:0] presc, input int peff,
                              input bit pen, input bit ptyp, input bit par_flip,
                              input bit stop_bit, input bit noise, input bit check_lat,
                              input bit mid_change);
        logic [10:0] bits;
        int          nb;
        exp_t        e;
        Prescale = presc;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        nb       = pen ? 11 : 10;
        bits     = 11'h7FF;
        bits[0]  = 1'b0;
        bits[8:1] = data;
        if (pen) begin
            bits[9]  = (^data) ^ ptyp ^ par_flip;
            bits[10] = stop_bit;
        end else begin
            bits[9]  = stop_bit;
        end
        e.pe = pen && par_flip;
        e.se = !stop_bit;
        e.dv = !e.pe && !e.se;
        if (e.dv) model_pdata = data;
        e.pdata = model_pdata;
        e.start = cyc + 1;
        e.lat   = check_lat ? (2 + nb * peff) : -1;
        sb.push_back(e);
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < peff; c++) begin
                RX_IN = (noise && c == peff / 2 + 1) ? ~bits[k] : bits[k];
                if (mid_change && k == 1 && c == 0) begin
                    Prescale = 6'd32;
                    PAR_EN   = ~pen;
                    PAR_TYP  = ~ptyp;
                end
                @(posedge CLK);
                #1;
            end
        end
    endtask

    initial begin
        logic [7:0] abort_data;
        RST      = 1'b1;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_P_DATA",     {24'd0, P_DATA}, 32'd0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_par_err",    {31'd0, par_err}, 32'd0);
        chk("rst_stp_err",    {31'd0, stp_err}, 32'd0);
        RST = 1'b0;
        idle(4);

        // Prescale 8, no parity.
        send_frame(8'hA5, 6'd8, 8, 0, 0, 0, 1, 0, 1, 0);
        idle(6);
        drain("drain_a5");

        // Prescale 16, even parity: good parity then bad parity.
        send_frame(8'h37, 6'd16, 16, 1, 0, 0, 1, 0, 1, 0);
        idle(6);
        drain("drain_37_ok");
        send_frame(8'h37, 6'd16, 16, 1, 0, 1, 1, 0, 1, 0);
        idle(6);
        drain("drain_37_par");

        // Prescale 32, odd parity, stop bit low then a held-low break.
        send_frame(8'hFF, 6'd32, 32, 1, 1, 0, 0, 0, 1, 0);
        RX_IN = 1'b0;
        repeat (100) begin
            @(posedge CLK);
            #1;
        end
        drain("drain_ff_stp");
        idle(8);
        send_frame(8'h12, 6'd32, 32, 1, 1, 0, 1, 0, 1, 0);
        idle(6);
        drain("drain_12");

        // Three-cycle start glitch at Prescale 16, then a real frame.
        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        idle(40);
        chk("glitch_no_strobe", sb.size(), 32'd0);
        send_frame(8'h5A, 6'd16, 16, 0, 0, 0, 1, 0, 1, 0);
        idle(6);
        drain("drain_5a");

        // Back-to-back frames with a noisy mid-bit sample in every bit.
        send_frame(8'h01, 6'd8, 8, 0, 0, 0, 1, 1, 1, 0);
        send_frame(8'h80, 6'd8, 8, 0, 0, 0, 1, 1, 0, 0);
        idle(6);
        drain("drain_b2b");

        // Illegal prescale behaves as 8; settings changed mid-frame are ignored.
        send_frame(8'h6E, 6'd12, 8, 0, 0, 0, 1, 0, 1, 1);
        idle(6);
        drain("drain_6e");

        // Reset in the middle of the data bits of 0xC3.
        Prescale   = 6'd8;
        PAR_EN     = 1'b0;
        abort_data = 8'hC3;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                RX_IN = (k == 0) ? 1'b0 : abort_data[k-1];
                @(posedge CLK);
                #1;
            end
        end
        RST   = 1'b1;
        RX_IN = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_pdata = 8'h00;
        chk("midrst_P_DATA",     {24'd0, P_DATA}, 32'd0);
        chk("midrst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("midrst_par_err",    {31'd0, par_err}, 32'd0);
        chk("midrst_stp_err",    {31'd0, stp_err}, 32'd0);
        idle(120);
        chk("midrst_no_strobe", sb.size(), 32'd0);
        send_frame(8'h3C, 6'd8, 8, 0, 0, 0, 1, 0, 1, 0);
        idle(10);
        drain("drain_3c");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
